data_if_master: RTL

Initiator side of the core data-memory interface: it accepts load/store commands on a valid/ready port and drives the split index/tag protocol (`req`/`gnt`, then a tag phase with `tag_valid`/`kill_req`, then `rvalid`/`rdata`). It returns in-order responses to the command source. It sits in front of the data memory or cache mock and serves as the UVM-side traffic driver and reusable LSU front end.

---
 rtl/data_if_pkg.sv | 31 +++
 rtl/data_if_tracker.sv | 105 ++++++++++
 rtl/data_if_master.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/data_if_pkg.sv
// Shared types and widths for the data-memory interface initiator.
package data_if_pkg;

  localparam int ADDR_W  = 56;
  localparam int INDEX_W = 12;
  localparam int TAG_W   = 44;
  localparam int DATA_W  = 64;
  localparam int BE_W    = 8;
  localparam int STAT_W  = 32;

  // Command captured on the valid/ready handshake
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // One granted request waiting for its rvalid
  typedef struct packed {
    logic we;
    logic kill;
  } tracker_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    TAG  = 2'd2
  } state_e;

endpackage

// File: rtl/data_if_tracker.sv
// In-order FIFO of granted requests awaiting rvalid. The tail entry's kill
// bit is written during the tag phase; when that entry is also the head and
// is popped in the same cycle, the live kill value is bypassed to head_o.
// A pop with nothing outstanding sets a sticky error and pops nothing.
module data_if_tracker
  import data_if_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             push_we_i,
  input  logic             kill_wr_i,
  input  logic             kill_i,
  input  logic             pop_i,
  output tracker_entry_t   head_o,
  output logic             pop_ok_o,
  output logic [CNT_W-1:0] count_o,
  output logic             err_o
);

  tracker_entry_t   entries_q [DEPTH];
  tracker_entry_t   entries_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] tail_ptr_s;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             empty_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Next-state computation for storage, pointers, count and error flag
  always_comb begin
    empty_s  = (count_q == {CNT_W{1'b0}});
    pop_ok_s = pop_i & ~empty_s;

    if (wr_ptr_q == {PTR_W{1'b0}}) begin
      tail_ptr_s = PTR_W'(DEPTH - 1);
    end else begin
      tail_ptr_s = wr_ptr_q - PTR_W'(1);
    end

    head_o = entries_q[rd_ptr_q];
    if (kill_wr_i && (count_q == CNT_W'(1))) begin
      head_o.kill = kill_i;
    end else begin
      head_o.kill = entries_q[rd_ptr_q].kill;
    end

    entries_d = entries_q;
    if (push_i) begin
      entries_d[wr_ptr_q] = '{we: push_we_i, kill: 1'b0};
    end else if (kill_wr_i) begin
      entries_d[tail_ptr_s].kill = kill_i;
    end else begin
      entries_d = entries_q;
    end

    wr_ptr_d = push_i   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    case ({push_i, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    err_d = err_q | (pop_i & empty_s);
  end

  // Tracker state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '{we: 1'b0, kill: 1'b0};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign pop_ok_o = pop_ok_s;
  assign count_o  = count_q;
  assign err_o    = err_q;

endmodule

// File: rtl/data_if_master.sv
// Initiator for the split index/tag data-memory protocol: IDLE -> REQ
// (held until grant) -> TAG (one cycle), with in-order responses.
// Optional statistics counters: define DATA_IF_MASTER_STATS_EN.
module data_if_master
  import data_if_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [ADDR_W-1:0]  cmd_addr_i,
  input  logic               cmd_we_i,
  input  logic [BE_W-1:0]    cmd_be_i,
  input  logic [DATA_W-1:0]  cmd_wdata_i,
  input  logic               kill_i,
  output logic               resp_valid_o,
  output logic               resp_we_o,
  output logic [DATA_W-1:0]  resp_rdata_o,
  output logic               err_o,
  output logic [INDEX_W-1:0] data_if_address_index_o,
  output logic [TAG_W-1:0]   data_if_address_tag_o,
  output logic [DATA_W-1:0]  data_if_data_wdata_o,
  output logic               data_if_data_req_o,
  output logic               data_if_data_we_o,
  output logic [BE_W-1:0]    data_if_data_be_o,
  output logic               data_if_kill_req_o,
  output logic               data_if_tag_valid_o,
  input  logic               data_if_data_gnt_i,
  input  logic               data_if_data_rvalid_i,
  input  logic [DATA_W-1:0]  data_if_data_rdata_i,
  output logic [STAT_W-1:0]  stat_req_o,
  output logic [STAT_W-1:0]  stat_kill_o,
  output logic [STAT_W-1:0]  stat_stall_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_we_q, resp_we_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              push_s, kill_wr_s, pop_ok_s, trk_err_s;
  tracker_entry_t    head_s;
  logic [CNT_W-1:0]  count_s;

  data_if_tracker #(.DEPTH(MAX_OUTSTANDING)) u_tracker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push_s),
    .push_we_i (cmd_q.we),
    .kill_wr_i (kill_wr_s),
    .kill_i    (kill_i),
    .pop_i     (data_if_data_rvalid_i),
    .head_o    (head_s),
    .pop_ok_o  (pop_ok_s),
    .count_o   (count_s),
    .err_o     (trk_err_s)
  );

  // FSM next state, command capture and tracker push/kill strobes
  always_comb begin
    cmd_ready_o = (state_q == IDLE) && (count_s < CNT_W'(MAX_OUTSTANDING));
    state_d     = state_q;
    cmd_d       = cmd_q;
    push_s      = (state_q == REQ) & data_if_data_gnt_i;
    kill_wr_s   = (state_q == TAG);
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          state_d = REQ;
          cmd_d   = '{addr: cmd_addr_i, we: cmd_we_i, be: cmd_be_i, wdata: cmd_wdata_i};
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (data_if_data_gnt_i) begin
          state_d = TAG;
        end else begin
          state_d = REQ;
        end
      end
      TAG:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs decoded from the registered state; zero otherwise
  always_comb begin
    data_if_address_index_o = {INDEX_W{1'b0}};
    data_if_address_tag_o   = {TAG_W{1'b0}};
    data_if_data_wdata_o    = {DATA_W{1'b0}};
    data_if_data_req_o      = 1'b0;
    data_if_data_we_o       = 1'b0;
    data_if_data_be_o       = {BE_W{1'b0}};
    data_if_kill_req_o      = 1'b0;
    data_if_tag_valid_o     = 1'b0;
    if (state_q == REQ) begin
      data_if_address_index_o = cmd_q.addr[INDEX_W-1:0];
      data_if_data_wdata_o    = cmd_q.wdata;
      data_if_data_req_o      = 1'b1;
      data_if_data_we_o       = cmd_q.we;
      data_if_data_be_o       = cmd_q.be;
    end else if (state_q == TAG) begin
      data_if_address_tag_o   = cmd_q.addr[ADDR_W-1:INDEX_W];
      data_if_kill_req_o      = kill_i;
      data_if_tag_valid_o     = 1'b1;
    end else begin
      data_if_data_req_o      = 1'b0;
    end
  end

  // Response for the popped head, suppressed when that request was killed
  always_comb begin
    resp_valid_d = pop_ok_s & ~head_s.kill;
    if (resp_valid_d) begin
      resp_we_d    = head_s.we;
      resp_rdata_d = data_if_data_rdata_i;
    end else begin
      resp_we_d    = 1'b0;
      resp_rdata_d = {DATA_W{1'b0}};
    end
  end

  // FSM, captured command and registered response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cmd_q        <= '{addr: {ADDR_W{1'b0}}, we: 1'b0, be: {BE_W{1'b0}}, wdata: {DATA_W{1'b0}}};
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_we_o    = resp_we_q;
  assign resp_rdata_o = resp_rdata_q;
  assign err_o        = trk_err_s;

`ifdef DATA_IF_MASTER_STATS_EN
  logic [STAT_W-1:0] stat_req_q, stat_req_d;
  logic [STAT_W-1:0] stat_kill_q, stat_kill_d;
  logic [STAT_W-1:0] stat_stall_q, stat_stall_d;

  // Wrapping event counters: grants, kills, stalled REQ cycles
  always_comb begin
    stat_req_d   = stat_req_q  + (push_s ? 32'd1 : 32'd0);
    stat_kill_d  = stat_kill_q + ((kill_wr_s && kill_i) ? 32'd1 : 32'd0);
    stat_stall_d = stat_stall_q +
                   (((state_q == REQ) && !data_if_data_gnt_i) ? 32'd1 : 32'd0);
  end

  // Statistics registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_req_q   <= 32'd0;
      stat_kill_q  <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      stat_req_q   <= stat_req_d;
      stat_kill_q  <= stat_kill_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_req_o   = stat_req_q;
  assign stat_kill_o  = stat_kill_q;
  assign stat_stall_o = stat_stall_q;
`else
  assign stat_req_o   = 32'd0;
  assign stat_kill_o  = 32'd0;
  assign stat_stall_o = 32'd0;
`endif

endmodule
